nib_ext_track: RTL and testbench

NIB_EXT_TRACK -- requirements
Module: nib_ext_track

---
 rtl/nib_ext_pkg.sv | 16 +
 rtl/nib_ext_reduce.sv | 55 +++++
 rtl/nib_ext_track.sv | 104 ++++++++++
 tb/tb_nib_ext_track.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nib_ext_pkg.sv
// Shared definitions for the extreme-value tracker: mode encodings and the
// index-width helper used by the top and the reduction tree.
package nib_ext_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  // Index width: ceil(log2(nch)), never less than one bit.
  function automatic int calc_iw(input int nch);
    int iw;
    iw = 1;
    while ((1 << iw) < nch) iw++;
    return iw;
  endfunction

endpackage

// File: rtl/nib_ext_reduce.sv
// Combinational NCH-way compare tree selecting the max or min channel value;
// on equal values the lower channel index always wins.
module nib_ext_reduce
  import nib_ext_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 4
) (
  input  logic [NCH*W-1:0]          data_i,
  input  logic                      mode_i,
  output logic [W-1:0]              val_o,
  output logic [calc_iw(NCH)-1:0]   idx_o
);

  localparam int IW = calc_iw(NCH);
  localparam int LV = IW;
  localparam int NP = 1 << LV;

  logic [W-1:0]  tv [0:LV][0:NP-1];
  logic [IW-1:0] ti [0:LV][0:NP-1];
  logic          tk [0:LV][0:NP-1];
  logic          take_r;

  // Leaves beyond NCH are padding and marked not-present so they never win.
  // The right (higher-index) node replaces the left only when strictly better.
  always_comb begin
    take_r = 1'b0;
    for (int l = 0; l <= LV; l++) begin
      for (int j = 0; j < NP; j++) begin
        tv[l][j] = '0;
        ti[l][j] = '0;
        tk[l][j] = 1'b0;
      end
    end
    for (int j = 0; j < NCH; j++) begin
      tv[0][j] = data_i[j*W +: W];
      ti[0][j] = IW'(j);
      tk[0][j] = 1'b1;
    end
    for (int l = 0; l < LV; l++) begin
      for (int j = 0; j < (NP >> (l + 1)); j++) begin
        take_r = tk[l][2*j+1] &&
                 (!tk[l][2*j] ||
                  ((mode_i == MODE_MIN) ? (tv[l][2*j+1] < tv[l][2*j])
                                        : (tv[l][2*j+1] > tv[l][2*j])));
        tv[l+1][j] = take_r ? tv[l][2*j+1] : tv[l][2*j];
        ti[l+1][j] = take_r ? ti[l][2*j+1] : ti[l][2*j];
        tk[l+1][j] = tk[l][2*j] | tk[l][2*j+1];
      end
    end
    val_o = tv[LV][0];
    idx_o = ti[LV][0];
  end

endmodule

// File: rtl/nib_ext_track.sv
// Pipelined extreme-value tracker: input register, reduction register, then a
// result register carrying change detection and a saturating hold counter.
module nib_ext_track
  import nib_ext_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 4,
  parameter int CW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [NCH*W-1:0]         data_in,
  input  logic                     mode,
  output logic                     out_valid,
  output logic [W-1:0]             ext_val,
  output logic [calc_iw(NCH)-1:0]  ext_idx,
  output logic                     chg,
  output logic [CW-1:0]            hold_cnt
);

  localparam int IW = calc_iw(NCH);
  localparam logic [CW-1:0] HOLD_MAX = '1;

  // Handshake: in_valid qualifies data_in/mode for one cycle only; there is no
  // ready, every valid sample is accepted and yields exactly one out_valid pulse.

  logic             s1_vld_q;
  logic [NCH*W-1:0] s1_data_q;
  logic             s1_mode_q;

  logic [W-1:0]     red_val;
  logic [IW-1:0]    red_idx;

  logic             s2_vld_q;
  logic [W-1:0]     s2_val_q;
  logic [IW-1:0]    s2_idx_q;

  logic             out_vld_q;
  logic             chg_q;
  logic             first_done_q;
  logic [W-1:0]     ext_val_q;
  logic [IW-1:0]    ext_idx_q;
  logic [CW-1:0]    hold_q;

  logic             chg_d;
  logic [CW-1:0]    hold_d;

  nib_ext_reduce #(.NCH(NCH), .W(W)) u_reduce (
    .data_i (s1_data_q),
    .mode_i (s1_mode_q),
    .val_o  (red_val),
    .idx_o  (red_idx)
  );

  // Only {idx, val} is compared; the mode that produced it does not matter.
  always_comb begin
    chg_d  = !first_done_q || (s2_idx_q != ext_idx_q) || (s2_val_q != ext_val_q);
    hold_d = chg_d ? '0 : ((hold_q == HOLD_MAX) ? hold_q : hold_q + CW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q     <= 1'b0;
      s1_data_q    <= '0;
      s1_mode_q    <= MODE_MAX;
      s2_vld_q     <= 1'b0;
      s2_val_q     <= '0;
      s2_idx_q     <= '0;
      out_vld_q    <= 1'b0;
      chg_q        <= 1'b0;
      first_done_q <= 1'b0;
      ext_val_q    <= '0;
      ext_idx_q    <= '0;
      hold_q       <= '0;
    end else begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= data_in;
        s1_mode_q <= mode;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_val_q <= red_val;
        s2_idx_q <= red_idx;
      end
      out_vld_q <= s2_vld_q;
      chg_q     <= s2_vld_q & chg_d;
      if (s2_vld_q) begin
        ext_val_q    <= s2_val_q;
        ext_idx_q    <= s2_idx_q;
        hold_q       <= hold_d;
        first_done_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign ext_val   = ext_val_q;
  assign ext_idx   = ext_idx_q;
  assign chg       = chg_q;
  assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_nib_ext_track.sv
// Bench for nib_ext_track: directed tables, corner sequences and a random run
// against a behavioural model, over three parameter sets.
module tb_nib_ext_track;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: NCH=4, W=4, CW=8
  logic        in_valid_a, mode_a;
  logic [15:0] data_a;
  logic        out_valid_a, chg_a;
  logic [3:0]  ext_val_a;
  logic [1:0]  ext_idx_a;
  logic [7:0]  hold_a;

  // Instance B: NCH=4, W=4, CW=2
  logic        in_valid_b, mode_b;
  logic [15:0] data_b;
  logic        out_valid_b, chg_b;
  logic [3:0]  ext_val_b;
  logic [1:0]  ext_idx_b;
  logic [1:0]  hold_b;

  // Instance C: NCH=2, W=1, CW=8
  logic        in_valid_c, mode_c;
  logic [1:0]  data_c;
  logic        out_valid_c, chg_c;
  logic [0:0]  ext_val_c;
  logic [0:0]  ext_idx_c;
  logic [7:0]  hold_c;

  nib_ext_track #(.NCH(4), .W(4), .CW(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .data_in(data_a), .mode(mode_a),
    .out_valid(out_valid_a), .ext_val(ext_val_a), .ext_idx(ext_idx_a), .chg(chg_a),
    .hold_cnt(hold_a)
  );

  nib_ext_track #(.NCH(4), .W(4), .CW(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .data_in(data_b), .mode(mode_b),
    .out_valid(out_valid_b), .ext_val(ext_val_b), .ext_idx(ext_idx_b), .chg(chg_b),
    .hold_cnt(hold_b)
  );

  nib_ext_track #(.NCH(2), .W(1), .CW(8)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid_c), .data_in(data_c), .mode(mode_c),
    .out_valid(out_valid_c), .ext_val(ext_val_c), .ext_idx(ext_idx_c), .chg(chg_c),
    .hold_cnt(hold_c)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard: expected {chg, idx[1:0], val[3:0], hold[7:0]} with the edge it is due.
  logic [14:0] exp_q[$];
  int          due_q[$];

  // Reference state: last valid result and hold count, plus last shown outputs.
  bit m_first;
  int m_val, m_idx, m_hold;
  int h_val, h_idx, h_hold;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Extreme of four 4-bit channels; scanning upward and replacing only on a
  // strictly better value keeps the lowest index on ties.
  function automatic void ref_ext(input logic [15:0] d, input logic m,
                                  output int val, output int idx);
    int v;
    val = int'(d[3:0]);
    idx = 0;
    for (int k = 1; k < 4; k++) begin
      v = int'((d >> (4 * k)) & 16'hF);
      if (m ? (v < val) : (v > val)) begin
        val = v;
        idx = k;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive instance A for one cycle and check its outputs after the edge.
  task automatic step_a(input logic rst, input logic v, input logic [15:0] d, input logic m);
    int ev, ei, eh;
    bit ec;
    logic [14:0] e;
    reset      = rst;
    in_valid_a = v;
    data_a     = d;
    mode_a     = m;
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      m_first = 0; m_val = 0; m_idx = 0; m_hold = 0;
      h_val = 0; h_idx = 0; h_hold = 0;
    end else if (v) begin
      ref_ext(d, m, ev, ei);
      ec = !m_first || (ev != m_val) || (ei != m_idx);
      eh = ec ? 0 : ((m_hold == 255) ? 255 : m_hold + 1);
      m_first = 1; m_val = ev; m_idx = ei; m_hold = eh;
      exp_q.push_back({ec, 2'(ei), 4'(ev), 8'(eh)});
      due_q.push_back(cyc + 2);
    end
    @(posedge clk);
    #1;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      e = exp_q.pop_front();
      h_val = int'(e[11:8]); h_idx = int'(e[13:12]); h_hold = int'(e[7:0]);
      cmp("a_out_valid", int'(out_valid_a), 1);
      cmp("a_chg", int'(chg_a), int'(e[14]));
    end else begin
      cmp("a_out_valid", int'(out_valid_a), 0);
      cmp("a_chg_idle", int'(chg_a), 0);
    end
    cmp("a_ext_val", int'(ext_val_a), h_val);
    cmp("a_ext_idx", int'(ext_idx_a), h_idx);
    cmp("a_hold_cnt", int'(hold_a), h_hold);
    cyc++;
  endtask

  typedef struct {
    logic [15:0] data;
    logic        mode;
    int          val;
    int          idx;
    int          chg;
    int          hold;
  } vec_t;

  typedef struct {
    logic [1:0] data;
    logic       mode;
    int         val;
    int         idx;
    int         chg;
    int         hold;
  } cvec_t;

  vec_t  tab[10];
  cvec_t ctab[5];
  int    sat_exp[6];

  initial begin
    int seen;
    logic [15:0] rd;
    logic rm, rv, rr;

    reset = 1'b1;
    in_valid_a = 0; mode_a = 0; data_a = '0;
    in_valid_b = 0; mode_b = 0; data_b = '0;
    in_valid_c = 0; mode_c = 0; data_c = '0;

    // Channel A is the low nibble: {D,C,B,A}.
    tab[0] = '{16'h4321, 1'b0, 4, 3, 1, 0};
    tab[1] = '{16'h4351, 1'b0, 5, 1, 1, 0};
    tab[2] = '{16'h4351, 1'b0, 5, 1, 0, 1};
    tab[3] = '{16'h4351, 1'b0, 5, 1, 0, 2};
    tab[4] = '{16'h3358, 1'b1, 3, 2, 1, 0};
    tab[5] = '{16'h3358, 1'b0, 8, 0, 1, 0};
    tab[6] = '{16'h7777, 1'b0, 7, 0, 1, 0};
    tab[7] = '{16'h7777, 1'b1, 7, 0, 0, 1};
    tab[8] = '{16'h2992, 1'b0, 9, 1, 1, 0};
    tab[9] = '{16'h2992, 1'b1, 2, 0, 1, 0};

    ctab[0] = '{2'b10, 1'b1, 0, 0, 1, 0};
    ctab[1] = '{2'b10, 1'b0, 1, 1, 1, 0};
    ctab[2] = '{2'b00, 1'b1, 0, 0, 1, 0};
    ctab[3] = '{2'b01, 1'b1, 0, 1, 1, 0};
    ctab[4] = '{2'b01, 1'b1, 0, 1, 0, 1};

    sat_exp = '{0, 1, 2, 3, 3, 3};

    // Reset state
    step_a(1'b1, 1'b0, 16'h0, 1'b0);
    step_a(1'b1, 1'b1, 16'hFFFF, 1'b0);
    cmp("rst_out_valid", int'(out_valid_a), 0);
    cmp("rst_ext_val", int'(ext_val_a), 0);
    cmp("rst_ext_idx", int'(ext_idx_a), 0);
    cmp("rst_chg", int'(chg_a), 0);
    cmp("rst_hold", int'(hold_a), 0);
    cmp("rst_b_out_valid", int'(out_valid_b), 0);
    cmp("rst_c_out_valid", int'(out_valid_c), 0);

    // Back-to-back table: the result for vector i appears two edges later.
    for (int i = 0; i < 12; i++) begin
      if (i < 10) step_a(1'b0, 1'b1, tab[i].data, tab[i].mode);
      else        step_a(1'b0, 1'b0, 16'h0, 1'b0);
      if (i >= 2) begin
        cmp("tab_out_valid", int'(out_valid_a), 1);
        cmp("tab_val", int'(ext_val_a), tab[i-2].val);
        cmp("tab_idx", int'(ext_idx_a), tab[i-2].idx);
        cmp("tab_chg", int'(chg_a), tab[i-2].chg);
        cmp("tab_hold", int'(hold_a), tab[i-2].hold);
      end
    end

    // Three idle cycles between identical samples keep the hold count going.
    step_a(1'b0, 1'b1, 16'h2992, 1'b1);
    step_a(1'b0, 1'b0, 16'h0, 1'b0);
    step_a(1'b0, 1'b0, 16'h0, 1'b0);
    cmp("gap1_chg", int'(chg_a), 0);
    cmp("gap1_hold", int'(hold_a), 1);
    step_a(1'b0, 1'b0, 16'h0, 1'b0);
    step_a(1'b0, 1'b1, 16'h2992, 1'b1);
    step_a(1'b0, 1'b0, 16'h0, 1'b0);
    step_a(1'b0, 1'b0, 16'h0, 1'b0);
    cmp("gap2_out_valid", int'(out_valid_a), 1);
    cmp("gap2_chg", int'(chg_a), 0);
    cmp("gap2_hold", int'(hold_a), 2);

    // Reset with two samples in flight plus a simultaneous valid.
    step_a(1'b0, 1'b1, 16'h1111, 1'b0);
    step_a(1'b0, 1'b1, 16'h2222, 1'b0);
    step_a(1'b1, 1'b1, 16'h3333, 1'b0);
    cmp("flush_rst_val", int'(ext_val_a), 0);
    cmp("flush_rst_hold", int'(hold_a), 0);
    seen = 0;
    repeat (4) begin
      step_a(1'b0, 1'b0, 16'h0, 1'b0);
      seen += int'(out_valid_a);
    end
    cmp("flush_no_valid", seen, 0);
    step_a(1'b0, 1'b1, 16'h2992, 1'b1);
    step_a(1'b0, 1'b0, 16'h0, 1'b0);
    step_a(1'b0, 1'b0, 16'h0, 1'b0);
    cmp("post_rst_valid", int'(out_valid_a), 1);
    cmp("post_rst_chg", int'(chg_a), 1);
    cmp("post_rst_hold", int'(hold_a), 0);

    // Random traffic with frequent repeats and occasional resets.
    rd = 16'h0;
    for (int n = 0; n < 500; n++) begin
      rr = ($urandom_range(0, 99) < 2);
      rv = ($urandom_range(0, 3) != 0);
      rm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6) rd = 16'($urandom);
      step_a(rr, rv, rd, rm);
    end
    repeat (3) step_a(1'b0, 1'b0, 16'h0, 1'b0);

    // Saturation with CW=2.
    for (int i = 0; i < 8; i++) begin
      in_valid_b = (i < 6);
      data_b     = 16'hABCD;
      mode_b     = 1'b0;
      tick();
      if (i >= 2) begin
        cmp("sat_out_valid", int'(out_valid_b), 1);
        cmp("sat_val", int'(ext_val_b), 13);
        cmp("sat_idx", int'(ext_idx_b), 0);
        cmp("sat_chg", int'(chg_b), (i == 2) ? 1 : 0);
        cmp("sat_hold", int'(hold_b), sat_exp[i-2]);
      end
    end
    in_valid_b = 1'b0;

    // NCH=2, W=1 corner cases.
    for (int i = 0; i < 7; i++) begin
      in_valid_c = (i < 5);
      data_c     = (i < 5) ? ctab[i].data : 2'b00;
      mode_c     = (i < 5) ? ctab[i].mode : 1'b0;
      tick();
      if (i >= 2) begin
        cmp("c_out_valid", int'(out_valid_c), 1);
        cmp("c_val", int'(ext_val_c), ctab[i-2].val);
        cmp("c_idx", int'(ext_idx_c), ctab[i-2].idx);
        cmp("c_chg", int'(chg_c), ctab[i-2].chg);
        cmp("c_hold", int'(hold_c), ctab[i-2].hold);
      end
    end
    in_valid_c = 1'b0;
    tick();
    cmp("c_idle_valid", int'(out_valid_c), 0);
    cmp("c_idle_chg", int'(chg_c), 0);
    cmp("c_idle_hold", int'(hold_c), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
